// File: rtl/rv_lsu_ctrl.sv
// RISC-V load/store unit controller: aligns stores onto byte lanes, extends loads,
// and sequences one bus transaction at a time with misalignment and timeout faults.
module rv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        fault_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a;
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  state_t      state_q;
  logic        busy_q, done_q, fault_q, fault_timeout_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
  logic [3:0]  mem_be_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wait_q;

  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;

  assign misalign_d = misaligned(funct3, addr[1:0]);
  assign be_d       = is_store ? store_be(funct3, addr[1:0]) : 4'b1111;
  assign wdata_d    = is_store ? store_data(funct3, wdata) : 32'b0;
  assign rdata_d    = load_extend(f3_q, lane_q, mem_rdata);

  // All outputs are registered; done/fault are one-cycle pulses tied to DONE/ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
      fault_timeout_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'b0;
      mem_be_q        <= 4'b0;
      mem_wdata_q     <= 32'b0;
      rdata_q         <= 32'b0;
      f3_q            <= 3'b0;
      lane_q          <= 2'b0;
      wait_q          <= 16'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (misalign_d) begin
              state_q         <= S_ERR;
              done_q          <= 1'b1;
              fault_q         <= 1'b1;
              fault_timeout_q <= 1'b0;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              f3_q        <= funct3;
              lane_q      <= addr[1:0];
              wait_q      <= 16'b0;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state_q         <= S_DONE;
            mem_req_q       <= 1'b0;
            done_q          <= 1'b1;
            fault_q         <= 1'b0;
            fault_timeout_q <= 1'b0;
            if (!mem_we_q) rdata_q <= rdata_d;
          end else if (wait_q == WAIT_LAST) begin
            state_q         <= S_ERR;
            mem_req_q       <= 1'b0;
            done_q          <= 1'b1;
            fault_q         <= 1'b1;
            fault_timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        S_DONE, S_ERR: begin
          state_q         <= S_IDLE;
          busy_q          <= 1'b0;
          done_q          <= 1'b0;
          fault_q         <= 1'b0;
          fault_timeout_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_timeout = fault_timeout_q;
  assign rdata         = rdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
